// File: rtl/fetch_stage_pkg.sv
// Shared RV32I definitions for the fetch stage.
//  NOP_INSTR    : canonical bubble (addi x0, x0, 0)
//  OP_*         : RV32I major opcodes, as seen in instr_d[6:0]
//  fetch_state_e: fetch FSM states
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus with a ready handshake.
//  imem_req   : fetch request valid              (master -> slave)
//  imem_addr  : word-aligned fetch address       (master -> slave)
//  imem_rdata : instruction word when ready      (slave -> master)
//  imem_ready : slave accepts request and returns data this cycle
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with enable and clear.
//  clk, reset : clock, synchronous active-high reset
//  en         : load the *_nxt values
//  clr        : load a NOP bubble; wins over en
//  instr/pc/pc_plus4/valid : registered IF/ID contents
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [31:0]     instr_nxt,
  input  logic [XLEN-1:0] pc_nxt,
  input  logic [XLEN-1:0] pc_plus4_nxt,
  input  logic            valid_nxt,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= instr_nxt;
      pc       <= pc_nxt;
      pc_plus4 <= pc_plus4_nxt;
      valid    <= valid_nxt;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, imem handshake, IF/ID load.
//  clk, reset          : clock, synchronous active-high reset
//  imem                : instruction-memory bus (master side)
//  stall_d, flush_d    : hazard unit hold / kill of IF/ID
//  pc_src_e, pc_target_e : taken branch/jal redirect from Execute
//  instr_d, pc_d, pc_plus4_d, valid_d : IF/ID outputs
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_stage_if.master      imem,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_e,
  input  logic [XLEN-1:0]    pc_target_e,
  output logic [31:0]        instr_d,
  output logic [XLEN-1:0]    pc_d,
  output logic [XLEN-1:0]    pc_plus4_d,
  output logic               valid_d
);

  localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_f, pc_f_nxt, pc_plus4_f;
  logic [XLEN-1:0] target, saved_target, saved_target_nxt;
  logic [XLEN-1:0] hold_pc, hold_pc_nxt;
  logic [31:0]     hold_instr, hold_instr_nxt;
  logic            transfer;
  logic            ifid_en, ifid_clr;
  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc, ifid_pc_plus4;

  assign target     = pc_target_e & ALIGN_MASK;
  assign pc_plus4_f = pc_f + FOUR;

  // No request while in reset or while a stalled word sits in the buffer.
  assign imem.imem_req  = !reset && (state != S_HOLD);
  assign imem.imem_addr = pc_f;
  assign transfer       = imem.imem_req && imem.imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      pc_f         <= RESET_PC;
      saved_target <= '0;
      hold_pc      <= '0;
      hold_instr   <= '0;
    end else begin
      state        <= state_nxt;
      pc_f         <= pc_f_nxt;
      saved_target <= saved_target_nxt;
      hold_pc      <= hold_pc_nxt;
      hold_instr   <= hold_instr_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_f_nxt         = pc_f;
    saved_target_nxt = saved_target;
    hold_pc_nxt      = hold_pc;
    hold_instr_nxt   = hold_instr;
    ifid_en          = 1'b0;
    ifid_clr         = 1'b0;
    ifid_instr       = hold_instr;
    ifid_pc          = hold_pc;

    unique case (state)
      S_FETCH: begin
        if (pc_src_e) begin
          // An accepted response is simply dropped; an outstanding one must
          // still complete at the old address before the target is issued.
          if (transfer || !imem.imem_req) begin
            pc_f_nxt = target;
          end else begin
            saved_target_nxt = target;
            state_nxt        = S_DRAIN;
          end
          ifid_clr = !stall_d;
        end else if (transfer) begin
          pc_f_nxt = pc_plus4_f;
          if (!stall_d) begin
            ifid_en    = 1'b1;
            ifid_instr = imem.imem_rdata;
            ifid_pc    = pc_f;
          end else begin
            hold_instr_nxt = imem.imem_rdata;
            hold_pc_nxt    = pc_f;
            state_nxt      = S_HOLD;
          end
        end else begin
          ifid_clr = !stall_d;
        end
      end
      S_HOLD: begin
        if (pc_src_e) begin
          pc_f_nxt  = target;
          state_nxt = S_FETCH;
          ifid_clr  = !stall_d;
        end else if (!stall_d && !flush_d) begin
          // A flush alone keeps the buffered word for the next free slot.
          ifid_en   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (pc_src_e) saved_target_nxt = target;
        if (imem.imem_ready) begin
          pc_f_nxt  = pc_src_e ? target : saved_target;
          state_nxt = S_FETCH;
        end
        ifid_clr = !stall_d;
      end
      default: state_nxt = S_FETCH;
    endcase

    if (flush_d) ifid_clr = 1'b1;
  end

  assign ifid_pc_plus4 = ifid_pc + FOUR;

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk          (clk),
    .reset        (reset),
    .en           (ifid_en),
    .clr          (ifid_clr),
    .instr_nxt    (ifid_instr),
    .pc_nxt       (ifid_pc),
    .pc_plus4_nxt (ifid_pc_plus4),
    .valid_nxt    (1'b1),
    .instr        (instr_d),
    .pc           (pc_d),
    .pc_plus4     (pc_plus4_d),
    .valid        (valid_d)
  );

endmodule
